// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge write arbiter.
//   state_e        - arbiter FSM state encoding
//   DEF_*          - default sizing used by the arbiter and its interface
//   idx_width()    - index width that never collapses to zero bits
package bridge_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int unsigned DEF_NUM_REQ       = 3;
   localparam int unsigned DEF_DATA_WIDTH    = 64;
   localparam int unsigned DEF_BURST_LEN     = 4;
   localparam int unsigned DEF_DEPTH_PER_REQ = 16;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bridge_wr_arbiter_if.sv
// Producer/buffer bundle for the bridge write arbiter.
//   req_valid/req_data/req_ready - per-requester streaming handshake
//   clear                        - pulse that empties every region
//   bank_*                       - buffer write port A
//   grant_idx/region_full/all_done - arbitration status
// Modport slave is the arbiter side, master is the producer/consumer side.
interface bridge_wr_arbiter_if
   import bridge_pkg::*;
#(
   parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH_PER_REQ = DEF_DEPTH_PER_REQ
);
   localparam int unsigned ADDR_WIDTH = $clog2(NUM_REQ * DEPTH_PER_REQ);
   localparam int unsigned IDX_WIDTH  = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          clear;
   logic                          bank_ena;
   logic                          bank_wea;
   logic [ADDR_WIDTH-1:0]         bank_addra;
   logic [DATA_WIDTH-1:0]         bank_dina;
   logic [IDX_WIDTH-1:0]          grant_idx;
   logic [NUM_REQ-1:0]            region_full;
   logic                          all_done;

   modport slave (
      input  req_valid, req_data, clear,
      output req_ready, bank_ena, bank_wea, bank_addra, bank_dina,
      output grant_idx, region_full, all_done
   );

   modport master (
      output req_valid, req_data, clear,
      input  req_ready, bank_ena, bank_wea, bank_addra, bank_dina,
      input  grant_idx, region_full, all_done
   );

endinterface

// File: rtl/rr_select.sv
// Round-robin pick: first set bit of eligible scanning upward from rr_ptr,
// wrapping modulo NUM_REQ.
//   eligible - requesters that may be granted
//   rr_ptr   - scan start position (< NUM_REQ)
//   idx      - chosen requester (0 when none)
//   found    - high when any requester was eligible
module rr_select #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);
   localparam int unsigned SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // rr_ptr < NUM_REQ, so one conditional subtract is a full modulo
         sum = {1'b0, rr_ptr} + SUM_W'(i);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/bridge_wr_arbiter.sv
// Burst write arbiter: NUM_REQ producers share one buffer write port. Each
// producer owns a DEPTH_PER_REQ-word region; grants are BURST_LEN beats and
// rotate round-robin. The write port is registered one cycle behind the
// handshake.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - bridge_wr_arbiter_if.slave (handshakes, clear, write port, status)
module bridge_wr_arbiter
   import bridge_pkg::*;
#(
   parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
   parameter int unsigned DEPTH_PER_REQ = DEF_DEPTH_PER_REQ
) (
   input logic                clk,
   input logic                rst_n,
   bridge_wr_arbiter_if.slave bus
);
   localparam int unsigned ADDR_WIDTH = $clog2(NUM_REQ * DEPTH_PER_REQ);
   localparam int unsigned IDX_W      = idx_width(NUM_REQ);
   localparam int unsigned PTR_W      = $clog2(DEPTH_PER_REQ + 1);
   localparam int unsigned BEAT_W     = idx_width(BURST_LEN);

   state_e                state_q;
   logic [NUM_REQ-1:0]    ready_q;
   logic [IDX_W-1:0]      grant_q;
   logic [IDX_W-1:0]      rr_ptr_q;
   logic [BEAT_W-1:0]     beat_q;
   logic [PTR_W-1:0]      wr_ptr_q [NUM_REQ];
   logic [NUM_REQ-1:0]    full_q;
   logic                  bank_en_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;

   logic [NUM_REQ-1:0]    eligible;
   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_found;
   logic                  hs;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic [PTR_W-1:0]      gnt_ptr;
   logic [ADDR_WIDTH-1:0] gnt_base;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [NUM_REQ-1:0]    full_next;
   logic [IDX_W-1:0]      rr_next;

   assign eligible = bus.req_valid & ~full_q;
   // ready_q is only ever set for the granted requester
   assign hs       = |(bus.req_valid & ready_q);
   assign rr_next  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_select (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .idx      (sel_idx),
      .found    (sel_found)
   );

   // Data, pointer and region base of the current grant
   always_comb begin
      gnt_data = '0;
      gnt_ptr  = '0;
      gnt_base = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant_q == IDX_W'(r)) begin
            gnt_data = bus.req_data[r*DATA_WIDTH +: DATA_WIDTH];
            gnt_ptr  = wr_ptr_q[r];
            gnt_base = ADDR_WIDTH'(r * DEPTH_PER_REQ);
         end
      end
      wr_addr = gnt_base + ADDR_WIDTH'(gnt_ptr);
   end

   // Full flag rises on the same edge the pointer reaches the region end, so
   // the following arbitration already sees the region as ineligible.
   always_comb begin
      full_next = full_q;
      if (hs && (gnt_ptr == PTR_W'(DEPTH_PER_REQ - 1))) begin
         full_next = full_q | (NUM_REQ'(1) << grant_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ready_q   <= '0;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         beat_q    <= '0;
         full_q    <= '0;
         for (int r = 0; r < NUM_REQ; r++) begin
            wr_ptr_q[r] <= '0;
         end
         bank_en_q <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
      end else begin
         // A beat accepted together with clear is still written
         bank_en_q <= hs;
         if (hs) begin
            addr_q <= wr_addr;
            din_q  <= gnt_data;
         end

         if (bus.clear) begin
            state_q  <= S_IDLE;
            ready_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            full_q   <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
               wr_ptr_q[r] <= '0;
            end
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (|eligible) begin
                     state_q <= S_ARB;
                  end
               end
               S_ARB: begin
                  if (sel_found) begin
                     grant_q <= sel_idx;
                     beat_q  <= '0;
                     ready_q <= NUM_REQ'(1) << sel_idx;
                     state_q <= S_BURST;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_BURST: begin
                  // Valid drops stall here with the grant held
                  if (hs) begin
                     if (gnt_ptr != PTR_W'(DEPTH_PER_REQ)) begin
                        wr_ptr_q[grant_q] <= gnt_ptr + PTR_W'(1);
                     end
                     full_q <= full_next;
                     beat_q <= beat_q + BEAT_W'(1);
                     if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        beat_q   <= '0;
                        ready_q  <= '0;
                        rr_ptr_q <= rr_next;
                        state_q  <= (&full_next) ? S_DONE : S_ARB;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_DONE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.req_ready   = ready_q;
   assign bus.bank_ena    = bank_en_q;
   assign bus.bank_wea    = bank_en_q;
   assign bus.bank_addra  = addr_q;
   assign bus.bank_dina   = din_q;
   assign bus.grant_idx   = grant_q;
   assign bus.region_full = full_q;
   assign bus.all_done    = &full_q;

endmodule

// File: tb/tb_bridge_wr_arbiter.sv
// Self-checking bench for bridge_wr_arbiter (3 requesters, 64-bit data,
// 4-beat bursts, 16-word regions).
module tb_bridge_wr_arbiter;
   localparam int NR = 3;
   localparam int DW = 64;
   localparam int BL = 4;
   localparam int DP = 16;

   localparam int M_IDLE  = 0;
   localparam int M_ARB   = 1;
   localparam int M_BURST = 2;
   localparam int M_DONE  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bridge_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH_PER_REQ(DP)) bus ();

   bridge_wr_arbiter #(
      .NUM_REQ       (NR),
      .DATA_WIDTH    (DW),
      .BURST_LEN     (BL),
      .DEPTH_PER_REQ (DP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   bit          chk_en   = 1'b0;
   int          cyc      = 0;
   logic [63:0] words [NR];
   int          writes [$];

   // Behavioural model: fill level per region, current grant, burst progress
   int          m_fill [NR];
   int          m_rr, m_g, m_beats, m_phase;
   logic [2:0]  m_ready;
   logic        m_ena;
   logic [5:0]  m_addr;
   logic [63:0] m_din;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   function automatic logic [2:0] m_full();
      logic [2:0] f;
      f = '0;
      for (int r = 0; r < NR; r++) begin
         if (m_fill[r] == DP) f = f | 3'(1 << r);
      end
      return f;
   endfunction

   task automatic model_step();
      logic [2:0] v;
      bit         hs;
      int         found;
      int         r;
      v = bus.req_valid;
      if (!rst_n) begin
         m_phase = M_IDLE; m_ready = '0; m_ena = 1'b0; m_addr = '0; m_din = '0;
         m_g = 0; m_rr = 0; m_beats = 0;
         for (int i = 0; i < NR; i++) m_fill[i] = 0;
      end else begin
         hs    = (m_ready & v) != 3'b000;
         m_ena = hs;
         if (hs) begin
            m_addr = 6'(m_g * DP + m_fill[m_g]);
            m_din  = words[m_g];
         end
         if (bus.clear) begin
            m_phase = M_IDLE; m_ready = '0; m_rr = 0; m_beats = 0;
            for (int i = 0; i < NR; i++) m_fill[i] = 0;
         end else begin
            case (m_phase)
               M_IDLE: if ((v & ~m_full()) != 3'b000) m_phase = M_ARB;
               M_ARB: begin
                  found = -1;
                  for (int k = 0; k < NR; k++) begin
                     r = (m_rr + k) % NR;
                     if (found < 0 && ((v >> r) & 3'b001) != 3'b000 && m_fill[r] < DP) found = r;
                  end
                  if (found >= 0) begin
                     m_g = found; m_ready = 3'(1 << found); m_beats = 0; m_phase = M_BURST;
                  end else begin
                     m_phase = M_IDLE;
                  end
               end
               M_BURST: begin
                  if (hs) begin
                     m_fill[m_g]++;
                     m_beats++;
                     if (m_beats == BL) begin
                        m_ready = '0;
                        m_rr    = (m_g + 1) % NR;
                        m_phase = (m_full() == 3'b111) ? M_DONE : M_ARB;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic drive_data();
      for (int r = 0; r < NR; r++) words[r] = {16'(r), 16'hA5A5, 32'(cyc)};
      bus.req_data = {words[2], words[1], words[0]};
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      drive_data();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_clear();
      bus.req_valid = '0;
      bus.clear     = 1'b1;
      tick();
      bus.clear = 1'b0;
      tick();
      writes.delete();
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_ready", bus.req_ready, m_ready);
         chk("cmp_ena", bus.bank_ena, m_ena);
         chk("cmp_wea", bus.bank_wea, m_ena);
         chk("cmp_addr", bus.bank_addra, m_addr);
         chk("cmp_dina", bus.bank_dina, m_din);
         chk("cmp_grant", bus.grant_idx, m_g);
         chk("cmp_full", bus.region_full, m_full());
         chk("cmp_done", bus.all_done, m_full() == 3'b111);
         if (bus.bank_ena === 1'b1) writes.push_back(int'(bus.bank_addra));
      end
   end

   initial begin
      bit r0_seen;
      bus.req_valid = '0;
      bus.clear     = 1'b0;
      drive_data();

      // Reset state
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_ena", bus.bank_ena, 0);
      chk("rst_addr", bus.bank_addra, 0);
      chk("rst_dina", bus.bank_dina, 0);
      chk("rst_full", bus.region_full, 0);
      chk("rst_done", bus.all_done, 0);
      rst_n = 1'b1;
      tick();
      writes.delete();

      // Only requester 0: four bursts fill region 0, then idle
      bus.req_valid = 3'b001;
      run(40);
      chk("s1_nwrites", writes.size(), 16);
      for (int i = 0; i < 16; i++) chk("s1_addr", (i < writes.size()) ? writes[i] : -1, i);
      chk("s1_full", bus.region_full, 3'b001);
      chk("s1_model_fill", m_fill[0], 16);
      chk("s1_idle_ready", bus.req_ready, 0);
      chk("s1_idle_ena", bus.bank_ena, 0);
      do_clear();

      // All three valid: grant order 0,1,2,... until every region is full
      bus.req_valid = 3'b111;
      run(75);
      chk("s2_nwrites", writes.size(), 48);
      for (int k = 0; k < 12; k++) begin
         for (int b = 0; b < BL; b++) begin
            chk("s2_addr", (4*k+b < writes.size()) ? writes[4*k+b] : -1,
                (k % 3) * 16 + (k / 3) * 4 + b);
         end
      end
      chk("s2_done", bus.all_done, 1);
      chk("s2_full", bus.region_full, 3'b111);
      run(5);
      chk("s2_hold_ready", bus.req_ready, 0);
      chk("s2_hold_done", bus.all_done, 1);
      do_clear();
      chk("s2_clear_done", bus.all_done, 0);

      // Requester 1 stalls for three cycles after beat 2
      bus.req_valid = 3'b010;
      for (int i = 0; i < 40 && !(m_fill[1] == 2 && m_phase == M_BURST); i++) tick();
      chk("s3_reach_beat2", m_fill[1], 2);
      bus.req_valid = 3'b000;
      repeat (3) begin
         tick();
         chk("s3_gap_ready", bus.req_ready, 3'b010);
         chk("s3_gap_ena", bus.bank_ena, 0);
      end
      bus.req_valid = 3'b010;
      for (int i = 0; i < 20 && m_fill[1] != 4; i++) tick();
      bus.req_valid = 3'b000;
      run(2);
      chk("s3_nwrites", writes.size(), 4);
      for (int i = 0; i < 4; i++) chk("s3_addr", (i < writes.size()) ? writes[i] : -1, 16 + i);
      chk("s3_release", bus.req_ready, 0);
      chk("s3_grant", bus.grant_idx, 1);
      do_clear();

      // Region 0 full: requester 0 never readied, only requester 2 served
      bus.req_valid = 3'b001;
      run(30);
      chk("s4_pre_full", bus.region_full, 3'b001);
      writes.delete();
      bus.req_valid = 3'b101;
      r0_seen = 1'b0;
      repeat (30) begin
         tick();
         if (bus.req_ready[0] !== 1'b0) r0_seen = 1'b1;
      end
      chk("s4_r0_ready", r0_seen, 0);
      chk("s4_nwrites", writes.size(), 16);
      for (int i = 0; i < 16; i++) chk("s4_addr", (i < writes.size()) ? writes[i] : -1, 32 + i);
      chk("s4_full", bus.region_full, 3'b101);
      do_clear();

      // Clear together with the 4th beat
      bus.req_valid = 3'b001;
      for (int i = 0; i < 30 && !(m_fill[0] == 3 && m_phase == M_BURST); i++) tick();
      chk("s5_reach_beat3", m_fill[0], 3);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("s5_beat_ena", bus.bank_ena, 1);
      chk("s5_beat_addr", bus.bank_addra, 3);
      chk("s5_full", bus.region_full, 0);
      chk("s5_ready", bus.req_ready, 0);
      tick();
      chk("s5_ready2", bus.req_ready, 0);
      chk("s5_ena2", bus.bank_ena, 0);
      writes.delete();
      for (int i = 0; i < 20 && writes.size() == 0; i++) tick();
      chk("s5_restart_addr", (writes.size() > 0) ? writes[0] : -1, 0);
      do_clear();

      // Reset during beat 2 discards the burst
      bus.req_valid = 3'b001;
      for (int i = 0; i < 30 && !(m_fill[0] == 1 && m_phase == M_BURST); i++) tick();
      chk("s6_reach_beat1", m_fill[0], 1);
      rst_n = 1'b0;
      tick();
      chk("s6_ena", bus.bank_ena, 0);
      chk("s6_wea", bus.bank_wea, 0);
      chk("s6_ready", bus.req_ready, 0);
      chk("s6_addr", bus.bank_addra, 0);
      chk("s6_dina", bus.bank_dina, 0);
      chk("s6_grant", bus.grant_idx, 0);
      chk("s6_full", bus.region_full, 0);
      chk("s6_done", bus.all_done, 0);
      rst_n = 1'b1;
      bus.req_valid = 3'b000;
      run(3);
      chk("s6_after_ena", bus.bank_ena, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bridge_wr_arbiter.md
BRIDGE_WR_ARBITER -- requirements
Module: bridge_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning number of producers (Q, K, V projections).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning write-word width.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning beats per grant.
REQ-004 SHALL have parameter DEPTH_PER_REQ, default 16, meaning words per requester region; must be a multiple of BURST_LEN.
REQ-005 SHALL have localparam ADDR_WIDTH = $clog2(NUM_REQ*DEPTH_PER_REQ).
REQ-006 clk  input  1  clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 req_valid  input  NUM_REQ  per-requester data valid.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  flat; requester r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid&ready.
REQ-011 clear  input  1  pulse; empties all regions.
REQ-012 bank_ena, bank_wea  output  1 each  buffer port A enable / write enable.
REQ-013 bank_addra  output  ADDR_WIDTH  write address.
REQ-014 bank_dina  output  DATA_WIDTH  write data.
REQ-015 grant_idx  output  $clog2(NUM_REQ)  current/last granted requester.
REQ-016 region_full  output  NUM_REQ  region r completely written.
REQ-017 all_done  output  1  all regions full.

Function
REQ-018 FSM states SHALL be S_IDLE, S_ARB, S_BURST, S_DONE.
REQ-019 S_IDLE -> S_ARB when any req_valid[r] with region_full[r]=0.
REQ-020 S_ARB SHALL, in one cycle, select the first eligible requester (valid and not full) scanning from rr_ptr upward modulo NUM_REQ, load grant_idx, clear beat counter, go to S_BURST; if none eligible, return to S_IDLE.
REQ-021 In S_BURST req_ready SHALL be high only for grant_idx; all other ready bits low in every state.
REQ-022 Each handshake SHALL increment beat counter and wr_ptr[grant_idx].
REQ-023 Grant SHALL be held until BURST_LEN beats transfer; a valid drop mid-burst stalls without releasing grant.
REQ-024 After the BURST_LEN-th beat: rr_ptr <= grant_idx+1 mod NUM_REQ; next state S_DONE if all regions full, else S_ARB.
REQ-025 Write port SHALL be registered: one cycle after a handshake, bank_ena=bank_wea=1, bank_addra = grant_idx*DEPTH_PER_REQ + wr_ptr (pre-increment), bank_dina = captured data; otherwise ena/wea=0.
REQ-026 region_full[r] SHALL set in the cycle after wr_ptr[r] reaches DEPTH_PER_REQ; wr_ptr saturates, no wrap.
REQ-027 all_done = AND of region_full; S_DONE holds until clear.
REQ-028 clear SHALL, next cycle, zero wr_ptr, region_full, beat counter, rr_ptr, go to S_IDLE, deassert all ready; clear coinciding with a handshake: clear wins, that beat still written (ena/wea next cycle), pointer not advanced.
REQ-029 Simultaneous eligible requests SHALL never grant the same requester twice in a row while another is eligible.

Reset
REQ-030 On rst_n=0 at a clock edge: state S_IDLE, req_ready=0, bank_ena=bank_wea=0, bank_addra=0, bank_dina=0, grant_idx=0, rr_ptr=0, all wr_ptr=0, region_full=0, all_done=0.
REQ-031 Reset mid-burst SHALL discard the burst; no write issues in the following cycle.

Structure
REQ-032 Shared package bridge_pkg SHALL hold the state enum type and default NUM_REQ/BURST_LEN/DEPTH_PER_REQ constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_select (inputs eligible mask, rr_ptr; outputs index, found).

Verification
REQ-034 Only req 0 valid continuously -> 16 writes at addr 0..15 in four bursts, region_full=3'b001, then idle.
REQ-035 All three valid continuously -> grant order 0,1,2,0,1,2...; first burst addresses 0-3, second 16-19, third 32-35; all_done after 48 writes.
REQ-036 Req 1 drops valid for 3 cycles after beat 2 -> grant held, ready stays high for req 1, no writes during gap, burst completes at 4 beats.
REQ-037 Region 0 full, req 0 and req 2 valid -> req 0 ready never high, only req 2 granted.
REQ-038 clear asserted with 4th beat of a burst -> beat written, next cycle wr_ptr=0, region_full=0, state S_IDLE.
REQ-039 rst_n low during beat 2 of a burst -> next cycle ena/wea=0, all outputs at reset values.
